// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: decodes MIPS loads/stores, runs a req/ack bus access with timeout and flush drain.
// Optional MAU_BIG_ENDIAN_EN selects big-endian byte-lane mapping; little-endian when undefined.
module mem_access_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [5:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              adel,
    output logic              ades,
    output logic              buserr,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} mauState_e;

    mauState_e        state, nextState;
    logic [5:0]       opReg;
    logic [1:0]       addrLo;
    logic [CNT_W-1:0] counter;

    logic       opKnown, opLoad, misaligned, reqLive, accept, timeoutHit;
    logic [1:0] opSize;
    logic [1:0] reqLane, regLane;
    logic       reqHiHalf, regHiHalf;
    logic [3:0] beNext;
    logic [31:0] wdataNext, loadData;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    // Opcode decode: size 0=byte, 1=half, 2=word
    always_comb begin
        opKnown = 1'b1;
        opSize  = 2'd0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: opSize = 2'd0;
            OP_LH, OP_LHU, OP_SH: opSize = 2'd1;
            OP_LW, OP_SW:         opSize = 2'd2;
            default:              opKnown = 1'b0;
        endcase
    end

    assign opLoad     = ~req_op[3];
    assign misaligned = ((opSize == 2'd1) && req_addr[0]) ||
                        ((opSize == 2'd2) && (req_addr[1:0] != 2'b00));
    assign reqLive    = (state == IDLE) && req_valid && opKnown && !flush;
    assign adel       = reqLive && opLoad && misaligned;
    assign ades       = reqLive && !opLoad && misaligned;
    assign accept     = reqLive && !misaligned;
    assign timeoutHit = (counter == CNT_LAST);

`ifdef MAU_BIG_ENDIAN_EN
    assign reqLane   = 2'd3 - req_addr[1:0];
    assign regLane   = 2'd3 - addrLo;
    assign reqHiHalf = ~req_addr[1];
    assign regHiHalf = ~addrLo[1];
`else
    assign reqLane   = req_addr[1:0];
    assign regLane   = addrLo;
    assign reqHiHalf = req_addr[1];
    assign regHiHalf = addrLo[1];
`endif

    // Store byte enables and lane-replicated write data; loads read the whole word
    always_comb begin
        beNext    = 4'b1111;
        wdataNext = req_wdata;
        if (!opLoad) begin
            case (opSize)
                2'd0: begin
                    beNext    = 4'b0001 << reqLane;
                    wdataNext = {4{req_wdata[7:0]}};
                end
                2'd1: begin
                    beNext    = reqHiHalf ? 4'b1100 : 4'b0011;
                    wdataNext = {2{req_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Lane select and extension of the returned word; stores yield zero
    always_comb begin
        laneByte = 8'h00;
        case (regLane)
            2'd0: laneByte = mem_rdata[7:0];
            2'd1: laneByte = mem_rdata[15:8];
            2'd2: laneByte = mem_rdata[23:16];
            2'd3: laneByte = mem_rdata[31:24];
            default: ;
        endcase
        laneHalf = regHiHalf ? mem_rdata[31:16] : mem_rdata[15:0];
        case (opReg)
            OP_LB:   loadData = {{24{laneByte[7]}}, laneByte};
            OP_LBU:  loadData = {24'h0, laneByte};
            OP_LH:   loadData = {{16{laneHalf[15]}}, laneHalf};
            OP_LHU:  loadData = {16'h0, laneHalf};
            OP_LW:   loadData = mem_rdata;
            default: loadData = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    nextState = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    nextState = DRAIN;
                end else begin
                    stall = 1'b1;
                    if (mem_ack || timeoutHit) nextState = RESP;
                end
            end
            RESP:  nextState = IDLE;
            DRAIN: begin
                stall = req_valid;
                if (mem_ack || timeoutHit) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign mem_req = (state == WAIT) || (state == DRAIN);
    assign done    = (state == RESP);

    // Request capture, timeout counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            opReg     <= 6'h0;
            addrLo    <= 2'b00;
            counter   <= '0;
            mem_wr    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            rdata     <= 32'h0;
            buserr    <= 1'b0;
        end else begin
            if (accept) begin
                opReg     <= req_op;
                addrLo    <= req_addr[1:0];
                counter   <= '0;
                mem_wr    <= !opLoad;
                mem_be    <= beNext;
                mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= wdataNext;
                buserr    <= 1'b0;
            end else if (mem_req) begin
                counter <= counter + CNT_W'(1);
            end
            if ((state == WAIT) && !flush) begin
                if (mem_ack) begin
                    rdata  <= loadData;
                    buserr <= 1'b0;
                end else if (timeoutHit) begin
                    rdata  <= 32'h0;
                    buserr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=4); expectations follow MAU_BIG_ENDIAN_EN if defined.
module tb_mem_access_unit;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
`ifdef MAU_BIG_ENDIAN_EN
    localparam bit BIG = 1'b1;
`else
    localparam bit BIG = 1'b0;
`endif

    logic        clk, rst, req_valid, flush, mem_ack;
    logic [5:0]  req_op;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        stall, done, adel, ades, buserr, mem_req, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    int nTests = 0;
    int nFail  = 0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .flush(flush), .stall(stall), .done(done), .rdata(rdata),
        .adel(adel), .ades(ades), .buserr(buserr), .mem_req(mem_req), .mem_wr(mem_wr),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, ".stall"},  32'(stall),   32'h0);
        checkEq({tag, ".done"},   32'(done),    32'h0);
        checkEq({tag, ".memReq"}, 32'(mem_req), 32'h0);
        checkEq({tag, ".memWr"},  32'(mem_wr),  32'h0);
        checkEq({tag, ".memBe"},  32'(mem_be),  32'h0);
        checkEq({tag, ".memAddr"}, mem_addr,    32'h0);
        checkEq({tag, ".memWdata"}, mem_wdata,  32'h0);
        checkEq({tag, ".rdata"},  rdata,        32'h0);
        checkEq({tag, ".buserr"}, 32'(buserr),  32'h0);
        checkEq({tag, ".adel"},   32'(adel),    32'h0);
        checkEq({tag, ".ades"},   32'(ades),    32'h0);
    endtask

    // One complete access; ack is driven in WAIT cycle number ackAt (0 = never)
    task automatic doAccess(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input int ackAt, input logic [31:0] rd,
                            input int expStall, input int expReq, input logic [31:0] expRdata,
                            input logic expBuserr, input logic [3:0] expBe, input logic [31:0] expWdata);
        int stallCnt = 0;
        int reqCnt = 0;
        logic gotDone = 1'b0;
        logic [31:0] gotRdata = 32'h0, gotWdata = 32'h0, gotAddr = 32'h0;
        logic gotBuserr = 1'b0, gotWr = 1'b0;
        logic [3:0] gotBe = 4'h0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        for (int c = 0; c < 64 && !gotDone; c++) begin
            #1;
            if (done) begin
                gotDone = 1'b1; gotRdata = rdata; gotBuserr = buserr;
                req_valid = 1'b0;
            end else begin
                if (stall) stallCnt++;
                if (mem_req) begin
                    reqCnt++;
                    if (reqCnt == 1) begin
                        gotBe = mem_be; gotAddr = mem_addr; gotWdata = mem_wdata; gotWr = mem_wr;
                    end
                    if (reqCnt == ackAt) begin
                        mem_ack = 1'b1; mem_rdata = rd;
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = 32'h0;
            end
        end
        req_valid = 1'b0;
        checkEq({tag, ".done"},     32'(gotDone),   32'h1);
        checkEq({tag, ".stallCyc"}, 32'(stallCnt),  32'(expStall));
        checkEq({tag, ".reqCyc"},   32'(reqCnt),    32'(expReq));
        checkEq({tag, ".rdata"},    gotRdata,       expRdata);
        checkEq({tag, ".buserr"},   32'(gotBuserr), 32'(expBuserr));
        checkEq({tag, ".memBe"},    32'(gotBe),     32'(expBe));
        checkEq({tag, ".memAddr"},  gotAddr,        {addr[31:2], 2'b00});
        checkEq({tag, ".memWr"},    32'(gotWr),     32'(op[3]));
        if (op[3]) checkEq({tag, ".memWdata"}, gotWdata, expWdata);
    endtask

    // Misaligned / suppressed request: no bus activity, stall stays low
    task automatic noAccess(input string tag, input logic [5:0] op, input logic [31:0] addr,
                            input logic fl, input logic expAdel, input logic expAdes);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; flush = fl;
        #1;
        checkEq({tag, ".adel"},  32'(adel),    32'(expAdel));
        checkEq({tag, ".ades"},  32'(ades),    32'(expAdes));
        checkEq({tag, ".stall"}, 32'(stall),   32'h0);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        #1;
        checkEq({tag, ".memReqAfter"}, 32'(mem_req), 32'h0);
        checkEq({tag, ".doneAfter"},   32'(done),    32'h0);
    endtask

    initial begin
        logic doneSeen;
        rst = 1'b1; req_valid = 1'b0; req_op = 6'h0; req_addr = 32'h0; req_wdata = 32'h0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        doAccess("lb",  OP_LB,  32'h1003, 32'h0, 3, 32'h80FF_1234, 4, 3,
                 BIG ? 32'h0000_0034 : 32'hFFFF_FF80, 1'b0, 4'hF, 32'h0);
        doAccess("sh",  OP_SH,  32'h2002, 32'h0000_ABCD, 1, 32'hFFFF_FFFF, 2, 1,
                 32'h0, 1'b0, BIG ? 4'b0011 : 4'b1100, 32'hABCD_ABCD);
        doAccess("lhu", OP_LHU, 32'h1002, 32'h0, 2, 32'h80FF_1234, 3, 2,
                 BIG ? 32'h0000_1234 : 32'h0000_80FF, 1'b0, 4'hF, 32'h0);
        doAccess("lh",  OP_LH,  32'h1002, 32'h0, 1, 32'h80FF_1234, 2, 1,
                 BIG ? 32'h0000_1234 : 32'hFFFF_80FF, 1'b0, 4'hF, 32'h0);
        doAccess("lbu", OP_LBU, 32'h1001, 32'h0, 1, 32'h80FF_1234, 2, 1,
                 BIG ? 32'h0000_00FF : 32'h0000_0012, 1'b0, 4'hF, 32'h0);
        doAccess("lbu0", OP_LBU, 32'h0, 32'h0, 1, 32'h1234_5678, 2, 1,
                 BIG ? 32'h0000_0012 : 32'h0000_0078, 1'b0, 4'hF, 32'h0);
        doAccess("sb",  OP_SB,  32'h3001, 32'h0000_00A5, 2, 32'h0, 3, 2,
                 32'h0, 1'b0, BIG ? 4'b0100 : 4'b0010, 32'hA5A5_A5A5);
        doAccess("sw",  OP_SW,  32'h3008, 32'h1234_5678, 1, 32'h0, 2, 1,
                 32'h0, 1'b0, 4'hF, 32'h1234_5678);
        doAccess("tmo", OP_LW,  32'h1000, 32'h0, 0, 32'h0, 5, 4, 32'h0, 1'b1, 4'hF, 32'h0);
        doAccess("lw",  OP_LW,  32'h1004, 32'h0, 1, 32'hDEAD_BEEF, 2, 1,
                 32'hDEAD_BEEF, 1'b0, 4'hF, 32'h0);

        noAccess("lwMis",  OP_LW, 32'h1001, 1'b0, 1'b1, 1'b0);
        noAccess("swMis",  OP_SW, 32'h1002, 1'b0, 1'b0, 1'b1);
        noAccess("lhMis",  OP_LH, 32'h1003, 1'b0, 1'b1, 1'b0);
        noAccess("flushMis", OP_LW, 32'h1001, 1'b1, 1'b0, 1'b0);
        noAccess("flushLw",  OP_LW, 32'h1000, 1'b1, 1'b0, 1'b0);
        noAccess("badOp",  6'b000000, 32'h1000, 1'b0, 1'b0, 1'b0);

        // Flush in second WAIT cycle; ack arrives two cycles later in DRAIN
        doneSeen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h1008;
        @(negedge clk); #1;
        checkEq("fl.wait1Req", 32'(mem_req), 32'h1);
        @(negedge clk);
        flush = 1'b1; #1;
        checkEq("fl.stallOnFlush", 32'(stall), 32'h0);
        checkEq("fl.reqOnFlush", 32'(mem_req), 32'h1);
        @(negedge clk);
        flush = 1'b0; req_valid = 1'b0; #1;
        doneSeen = doneSeen | done;
        checkEq("fl.drainReq", 32'(mem_req), 32'h1);
        checkEq("fl.drainStall0", 32'(stall), 32'h0);
        @(negedge clk);
        req_valid = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5555_5555; #1;
        doneSeen = doneSeen | done;
        checkEq("fl.drainStall1", 32'(stall), 32'h1);
        checkEq("fl.ackReq", 32'(mem_req), 32'h1);
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0; #1;
        doneSeen = doneSeen | done;
        checkEq("fl.reqDropped", 32'(mem_req), 32'h0);
        @(negedge clk); #1;
        doneSeen = doneSeen | done;
        checkEq("fl.doneNever", 32'(doneSeen), 32'h0);

        // Reset in the middle of a store's WAIT phase
        @(negedge clk);
        req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h4000; req_wdata = 32'h1122_3344;
        @(negedge clk); #1;
        checkEq("rst.preWdata", mem_wdata, 32'h1122_3344);
        checkEq("rst.preReq", 32'(mem_req), 32'h1);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;
        checkAllZero("rstMid");
        rst = 1'b0;
        @(negedge clk); #1;
        checkEq("rst.stayIdle", 32'(mem_req), 32'h0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
